// File: rtl/div_sqrt_mant_iter_if.sv
// Handshake and data bundle for the iterative mantissa divide/sqrt engine.
interface div_sqrt_mant_iter_if #(
  parameter int unsigned MANT_W = 24,
  parameter int unsigned PC_W   = $clog2(MANT_W)
);
  logic              start;
  logic              kill;
  logic              div_enable;
  logic              sqrt_enable;
  logic              sqrt_odd;
  logic [PC_W-1:0]   precision_ctl;
  logic [MANT_W-1:0] operand_a;
  logic [MANT_W-1:0] operand_b;
  logic              ready;
  logic              done;
  logic [MANT_W:0]   result;
  logic              sticky;

  modport master (
    output start, kill, div_enable, sqrt_enable, sqrt_odd, precision_ctl, operand_a, operand_b,
    input  ready, done, result, sticky
  );

  modport slave (
    input  start, kill, div_enable, sqrt_enable, sqrt_odd, precision_ctl, operand_a, operand_b,
    output ready, done, result, sticky
  );
endinterface

// File: rtl/div_sqrt_mant_iter.sv
// Iterative radix-2 mantissa divider / square-root engine, ITER_PER_CYC iterations per clock.
// Optional early termination on a zero partial remainder: define DIV_SQRT_EARLY_TERM_EN.
module div_sqrt_mant_iter #(
  parameter int unsigned MANT_W       = 24,
  parameter int unsigned ITER_PER_CYC = 1,
  parameter int unsigned PC_W         = $clog2(MANT_W)
) (
  input logic                 clk,
  input logic                 rst,
  div_sqrt_mant_iter_if.slave bus
);
  // Remainder is wide enough for the sqrt bring-down of two bits against a full-length root.
  localparam int unsigned RW    = MANT_W + 4;
  localparam int unsigned RES_W = MANT_W + 1;
  localparam int unsigned RAD_W = ((MANT_W + 2) / 2) * 2;
  localparam int unsigned CNT_W = $clog2(MANT_W + 2) + 1;

  typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

  state_e            state_q, state_d;
  logic [RW-1:0]     rem_q, rem_d, rem_it, r2, trial, dvs;
  logic [RES_W-1:0]  q_q, q_d, q_it, result_q, result_d, rad_src;
  logic [RAD_W-1:0]  rad_q, rad_d, rad_it;
  logic [MANT_W-1:0] divisor_q, divisor_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_it, n_q, n_d, p_sel;
  logic [PC_W-1:0]   pc;
  logic              sqrt_q, sqrt_d, sticky_q, sticky_d;
  logic              accept, div_zero, early;

  assign pc       = bus.precision_ctl;
  assign accept   = bus.start && (bus.div_enable || bus.sqrt_enable) && (state_q != StIter);
  assign div_zero = !sqrt_q && (divisor_q == '0);
  assign rad_src  = bus.sqrt_odd ? {bus.operand_a, 1'b0} : {1'b0, bus.operand_a};

  always_comb begin
    p_sel = CNT_W'(MANT_W - 1);
    if (pc != '0 && 32'(pc) < MANT_W) p_sel = CNT_W'(pc);
  end

  // Up to ITER_PER_CYC radix-2 steps; steps past the last requested bit leave state untouched.
  always_comb begin
    rem_it = rem_q;
    q_it   = q_q;
    rad_it = rad_q;
    cnt_it = cnt_q;
    r2     = '0;
    trial  = '0;
    dvs    = RW'(divisor_q);
    for (int i = 0; i < int'(ITER_PER_CYC); i++) begin
      if (cnt_it < n_q) begin
        if (sqrt_q) begin
          r2     = {rem_it[RW-3:0], rad_it[RAD_W-1 -: 2]};
          trial  = {1'b0, q_it, 2'b01};
          rad_it = {rad_it[RAD_W-3:0], 2'b00};
          if (r2 >= trial) begin
            rem_it = r2 - trial;
            q_it   = {q_it[RES_W-2:0], 1'b1};
          end else begin
            rem_it = r2;
            q_it   = {q_it[RES_W-2:0], 1'b0};
          end
        end else if (rem_it >= dvs) begin
          r2     = rem_it - dvs;
          rem_it = {r2[RW-2:0], 1'b0};
          q_it   = {q_it[RES_W-2:0], 1'b1};
        end else begin
          rem_it = {rem_it[RW-2:0], 1'b0};
          q_it   = {q_it[RES_W-2:0], 1'b0};
        end
        cnt_it = cnt_it + CNT_W'(1);
      end
    end
  end

`ifdef DIV_SQRT_EARLY_TERM_EN
  assign early = (rem_it == '0) && !div_zero;
`else
  assign early = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    q_d       = q_q;
    rad_d     = rad_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    sqrt_d    = sqrt_q;
    divisor_d = divisor_q;
    result_d  = result_q;
    sticky_d  = sticky_q;
    case (state_q)
      StIter: begin
        if (bus.kill) begin
          state_d = StIdle;
        end else begin
          rem_d = rem_it;
          q_d   = q_it;
          rad_d = rad_it;
          cnt_d = cnt_it;
          if (cnt_it >= n_q || early) begin
            state_d  = StDone;
            result_d = q_it << (CNT_W'(RES_W) - cnt_it);
            sticky_d = (rem_it != '0) || div_zero;
          end
        end
      end
      default: begin
        state_d = StIdle;
        if (accept) begin
          state_d   = StIter;
          sqrt_d    = !bus.div_enable;
          divisor_d = bus.operand_b;
          n_d       = p_sel + CNT_W'(2);
          cnt_d     = '0;
          q_d       = '0;
          rem_d     = bus.div_enable ? RW'(bus.operand_a) : '0;
          rad_d     = RAD_W'(rad_src) << (RAD_W - RES_W);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      rem_q     <= '0;
      q_q       <= '0;
      rad_q     <= '0;
      cnt_q     <= '0;
      n_q       <= '0;
      sqrt_q    <= 1'b0;
      divisor_q <= '0;
      result_q  <= '0;
      sticky_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      q_q       <= q_d;
      rad_q     <= rad_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      sqrt_q    <= sqrt_d;
      divisor_q <= divisor_d;
      result_q  <= result_d;
      sticky_q  <= sticky_d;
    end
  end

  assign bus.ready  = (state_q != StIter);
  assign bus.done   = (state_q == StDone);
  assign bus.result = result_q;
  assign bus.sticky = sticky_q;

endmodule

// File: tb/tb_div_sqrt_mant_iter.sv
// Self-checking bench: two engines (1 and 2 iterations/cycle) against an arithmetic reference.
module tb_div_sqrt_mant_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [24:0] last_r1 = '0, last_r2 = '0;
  bit          last_s1 = 1'b0, last_s2 = 1'b0;

  div_sqrt_mant_iter_if #(.MANT_W(24), .PC_W(5)) bus1 ();
  div_sqrt_mant_iter_if #(.MANT_W(24), .PC_W(5)) bus2 ();

  assign bus2.start         = bus1.start;
  assign bus2.kill          = bus1.kill;
  assign bus2.div_enable    = bus1.div_enable;
  assign bus2.sqrt_enable   = bus1.sqrt_enable;
  assign bus2.sqrt_odd      = bus1.sqrt_odd;
  assign bus2.precision_ctl = bus1.precision_ctl;
  assign bus2.operand_a     = bus1.operand_a;
  assign bus2.operand_b     = bus1.operand_b;

  div_sqrt_mant_iter #(.MANT_W(24), .ITER_PER_CYC(1), .PC_W(5)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );
  div_sqrt_mant_iter #(.MANT_W(24), .ITER_PER_CYC(2), .PC_W(5)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned isqrt(input longint unsigned y);
    longint unsigned lo = 0, hi = 64'd1 << 26, mid;
    while (lo < hi) begin
      mid = (lo + hi + 1) >> 1;
      if (mid * mid <= y) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  // First k result bits as an integer, plus the exact leftover of that partial computation.
  task automatic part(input logic [23:0] a, input logic [23:0] b, input bit sq, input bit odd,
                      input int k, output longint unsigned q, output longint unsigned rem);
    longint unsigned x, y;
    if (!sq) begin
      if (b == 0) begin
        q = (64'd1 << k) - 1;
        rem = 1;
      end else begin
        y = 64'(a) << (k - 1);
        q = y / 64'(b);
        rem = y % 64'(b);
      end
    end else begin
      x = odd ? (64'(a) << 2) : (64'(a) << 1);
      if (2 * k >= 26) y = x << (2 * k - 26);
      else y = x >> (26 - 2 * k);
      q = isqrt(y);
      rem = y - q * q;
    end
  endtask

  task automatic model(input logic [23:0] a, input logic [23:0] b, input bit sq, input bit odd,
                       input int p_raw, input int ipc,
                       output logic [24:0] res, output bit stk, output int lat);
    int n, c;
    longint unsigned q, rem;
    n = ((p_raw == 0 || p_raw > 23) ? 23 : p_raw) + 2;
    c = (n + ipc - 1) / ipc;
    lat = c + 1;
    part(a, b, sq, odd, n, q, rem);
    res = 25'(q << (25 - n));
    stk = (rem != 0);
`ifdef DIV_SQRT_EARLY_TERM_EN
    for (int k = 1; k < c; k++) begin
      part(a, b, sq, odd, k * ipc, q, rem);
      if (rem == 0 && (sq || b != 0)) begin
        res = 25'(q << (25 - k * ipc));
        stk = 1'b0;
        lat = k + 1;
        break;
      end
    end
`endif
  endtask

  task automatic drive_start(input logic [23:0] a, input logic [23:0] b, input bit dv,
                             input bit sq, input bit odd, input int p, input bit kill0);
    bus1.operand_a     = a;
    bus1.operand_b     = b;
    bus1.div_enable    = dv;
    bus1.sqrt_enable   = sq;
    bus1.sqrt_odd      = odd;
    bus1.precision_ctl = 5'(p);
    bus1.kill          = kill0;
    bus1.start         = 1'b1;
  endtask

  task automatic scramble_inputs();
    bus1.start         = 1'b0;
    bus1.kill          = 1'b0;
    bus1.div_enable    = 1'b0;
    bus1.sqrt_enable   = 1'b0;
    bus1.operand_a     = 24'($urandom);
    bus1.operand_b     = 24'($urandom);
    bus1.sqrt_odd      = 1'($urandom);
    bus1.precision_ctl = 5'($urandom);
  endtask

  task automatic run_op(input string tag, input logic [23:0] a, input logic [23:0] b,
                        input bit dv, input bit sq, input bit odd, input int p, input bit kill0);
    logic [24:0] er1, er2;
    bit          es1, es2;
    int          el1, el2, d1, d2;
    model(a, b, !dv, odd, p, 1, er1, es1, el1);
    model(a, b, !dv, odd, p, 2, er2, es2, el2);
    @(negedge clk);
    drive_start(a, b, dv, sq, odd, p, kill0);
    @(negedge clk);
    scramble_inputs();
    chk({tag, "_busy1"}, 64'(bus1.ready), 64'd0);
    chk({tag, "_busy2"}, 64'(bus2.ready), 64'd0);
    d1 = 0;
    d2 = 0;
    for (int k = 1; k <= 60; k++) begin
      if (k > 1) @(negedge clk);
      if (bus1.done && d1 == 0) d1 = k;
      if (bus2.done && d2 == 0) d2 = k;
      if (d1 != 0 && d2 != 0) break;
    end
    chk({tag, "_lat1"}, 64'(d1), 64'(el1));
    chk({tag, "_lat2"}, 64'(d2), 64'(el2));
    chk({tag, "_res1"}, 64'(bus1.result), 64'(er1));
    chk({tag, "_res2"}, 64'(bus2.result), 64'(er2));
    chk({tag, "_stk1"}, 64'(bus1.sticky), 64'(es1));
    chk({tag, "_stk2"}, 64'(bus2.sticky), 64'(es2));
    last_r1 = er1;
    last_r2 = er2;
    last_s1 = es1;
    last_s2 = es2;
  endtask

  initial begin
    logic [24:0] er;
    bit          es;
    int          el1, el2, d1a, d1b, d2a, d2b, ndone;
    logic [23:0] ra, rb;
    bit          rdv, rodd;

    scramble_inputs();
    #1;
    chk("rst_ready", 64'(bus1.ready), 64'd1);
    chk("rst_done", 64'(bus1.done), 64'd0);
    chk("rst_result", 64'(bus1.result), 64'd0);
    chk("rst_sticky", 64'(bus2.sticky), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op("div_exact", 24'h800000, 24'h800000, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    run_op("div_third", 24'h800000, 24'hC00000, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    run_op("div_p10", 24'h800000, 24'hC00000, 1'b1, 1'b0, 1'b0, 10, 1'b0);
    run_op("sqrt2", 24'h800000, 24'h000000, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    run_op("both_en", 24'hC00000, 24'h900000, 1'b1, 1'b1, 1'b1, 7, 1'b0);
    run_op("div_zero", 24'hA5A5A5, 24'h000000, 1'b1, 1'b0, 1'b0, 5, 1'b0);
    run_op("sqrt_pclip", 24'hF00001, 24'h123456, 1'b0, 1'b1, 1'b0, 31, 1'b1);

    // Start with no enable is ignored.
    @(negedge clk);
    drive_start(24'h900000, 24'h800000, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    @(negedge clk);
    scramble_inputs();
    chk("noen_ready1", 64'(bus1.ready), 64'd1);
    chk("noen_ready2", 64'(bus2.ready), 64'd1);

    // Kill in cycle 5 of a division.
    drive_start(24'hE00000, 24'h812345, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    @(negedge clk);
    scramble_inputs();
    repeat (4) @(negedge clk);
    bus1.kill = 1'b1;
    @(negedge clk);
    bus1.kill = 1'b0;
    chk("kill_ready1", 64'(bus1.ready), 64'd1);
    chk("kill_ready2", 64'(bus2.ready), 64'd1);
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      if (bus1.done || bus2.done) ndone++;
      @(negedge clk);
    end
    chk("kill_nodone", 64'(ndone), 64'd0);
    chk("kill_res1", 64'(bus1.result), 64'(last_r1));
    chk("kill_res2", 64'(bus2.result), 64'(last_r2));
    chk("kill_stk1", 64'(bus1.sticky), 64'(last_s1));
    run_op("after_kill", 24'hE00000, 24'h812345, 1'b1, 1'b0, 1'b0, 0, 1'b0);

    // Start held high: each Done cycle re-accepts it, ITER cycles ignore it.
    model(24'h800000, 24'h800000, 1'b0, 1'b0, 10, 1, er, es, el1);
    model(24'h800000, 24'h800000, 1'b0, 1'b0, 10, 2, er, es, el2);
    @(negedge clk);
    drive_start(24'h800000, 24'h800000, 1'b1, 1'b0, 1'b0, 10, 1'b0);
    d1a = 0; d1b = 0; d2a = 0; d2b = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (bus1.done) begin
        if (d1a == 0) d1a = k;
        else if (d1b == 0) d1b = k;
      end
      if (bus2.done) begin
        if (d2a == 0) d2a = k;
        else if (d2b == 0) d2b = k;
      end
    end
    scramble_inputs();
    chk("b2b_first1", 64'(d1a), 64'(el1));
    chk("b2b_second1", 64'(d1b), 64'(2 * el1));
    chk("b2b_first2", 64'(d2a), 64'(el2));
    chk("b2b_second2", 64'(d2b), 64'(2 * el2));
    chk("b2b_res1", 64'(bus1.result), 64'(er));
    repeat (30) @(negedge clk);

    for (int t = 0; t < 12; t++) begin
      ra   = 24'($urandom) | 24'h800000;
      rb   = ($urandom_range(0, 7) == 0) ? 24'h0 : (24'($urandom) | 24'h800000);
      rdv  = 1'($urandom);
      rodd = 1'($urandom);
      run_op("rand", ra, rb, rdv, !rdv || 1'($urandom), rodd, int'($urandom_range(0, 31)),
             1'($urandom));
    end

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    drive_start(24'hC90FDA, 24'hADF85C, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    @(negedge clk);
    scramble_inputs();
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_ready1", 64'(bus1.ready), 64'd1);
    chk("arst_ready2", 64'(bus2.ready), 64'd1);
    chk("arst_res1", 64'(bus1.result), 64'd0);
    chk("arst_res2", 64'(bus2.result), 64'd0);
    chk("arst_stk1", 64'(bus1.sticky), 64'd0);
    chk("arst_done2", 64'(bus2.done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst", 24'hB504F3, 24'h000000, 1'b0, 1'b1, 1'b0, 12, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/div_sqrt_mant_iter.md
# div_sqrt_mant_iter

Parametrised iterative mantissa engine for the divide/square-root unit. It generalises the fixed single-precision datapath (23-bit mantissa, 5-bit precision control) to any mantissa width, up to FP64, and adds a configurable number of iterations per cycle. It sits between the operand pre-normaliser and the rounding/packing stage. It takes normalised mantissas and produces a left-aligned quotient or root with guard and sticky information.

## Interface
- MANT_W, 24: mantissa width including hidden bit (24 = FP32, 53 = FP64).
- ITER_PER_CYC, 1: radix-2 iterations per clock, 1..4.
- PC_W, $clog2(MANT_W): precision-control width.

- Clk_CI  in  1  clock.
- Rst_RI  in  1  reset; asynchronous, active-high.
- Start_SI  in  1  start request, accepted only when Ready_SO=1.
- Kill_SI  in  1  abort current operation.
- Div_enable_SI  in  1  start a division (wins if both enables are high).
- Sqrt_enable_SI  in  1  start a square root.
- Sqrt_odd_SI  in  1  sqrt only: exponent odd, radicand = 2*a.
- Precision_ctl_SI  in  PC_W  fraction bits P; 0 or values above MANT_W-1 select MANT_W-1.
- Operand_a_DI  in  MANT_W  dividend or radicand mantissa, MSB set.
- Operand_b_DI  in  MANT_W  divisor mantissa.
- Ready_SO  out  1  can accept Start.
- Done_SO  out  1  one-cycle result-valid pulse.
- Result_DO  out  MANT_W+1  bit MANT_W = integer bit, then fraction bits, bit 0 = guard.
- Sticky_SO  out  1  final partial remainder is nonzero.

## Operation
- **States:**
  - IDLE: Ready_SO=1.
  - ITER: Ready_SO=0.
  - DONE: Ready_SO=1, Done_SO=1.
- **Start acceptance:** Start_SI with Ready_SO=1 and at least one enable high latches the operands, the mode and P, then moves to ITER. Start_SI with no enable high is ignored.
- **Bit count:** N = P+2 bits are produced (integer bit, P fraction bits, guard bit). They occupy the N MSBs of Result_DO; all lower bits are 0.
- **Division (restoring):**
  - Remainder R is MANT_W+2 bits, initialised to a.
  - Per iteration: if R >= b, emit 1 and set R -= b; otherwise emit 0. Then R <<= 1.
  - b = 0 yields all-ones quotient bits and Sticky=1, at normal latency.
- **Square root (digit-by-digit):**
  - Radicand = Sqrt_odd_SI ? a<<1 : a, giving a value in [1,4).
  - Per iteration: bring down 2 radicand bits (zeros once the radicand is exhausted) into R. Trial T = (Q<<2)|1.
  - If R >= T: R -= T and Q = (Q<<1)|1. Otherwise Q <<= 1.
- **Iteration cycles:** ceil(N/ITER_PER_CYC). Iterations beyond N in the last cycle are suppressed and do not change R.
- **DONE:**
  - Result_DO and Sticky_SO (R != 0) stay held until the next accepted Start.
  - DONE lasts one cycle, then IDLE.
  - Start in the DONE cycle is accepted: back-to-back operation.
- **Kill:**
  - Kill_SI in ITER: IDLE at the next edge, no Done_SO, Result_DO unchanged from the previous operation.
  - Kill_SI in IDLE or DONE: no effect on a Start in the same cycle; Kill has priority only over ITER.
- **Busy:** Start during ITER is ignored.
- **Reset:**
  - All outputs 0 except Ready_SO=1. State = IDLE.
  - Reset mid-ITER aborts immediately; no Done_SO.

## Timing
- Start accepted at edge 0. Done_SO is high in cycle ceil(N/ITER_PER_CYC)+1.
- Result_DO and Sticky_SO are registered and valid in the Done cycle.
- Ready_SO drops in the cycle after the accepted Start.
- No combinational path from inputs to outputs.

## Configuration
- DIV_SQRT_EARLY_TERM_EN defined:
  - After any iteration cycle, R == 0 forces DONE next.
  - Remaining result bits are 0 and Sticky=0.
  - Latency becomes data-dependent, at least 2 cycles.
- Undefined: latency is fixed at ceil(N/ITER_PER_CYC)+1 regardless of data.

## Test plan
MANT_W=24, ITER_PER_CYC=1 unless stated.
- **Div exact:** a=b=0x800000, P=0 -> Done at cycle 26 (cycle 2 with DIV_SQRT_EARLY_TERM_EN), Result=0x1000000, Sticky=0.
- **Div inexact:** a=0x800000, b=0xC00000, P=0 -> Result=0x0AAAAAA, Sticky=1. With P=10: Done at cycle 13, Result=0x0AAA000, Sticky=1.
- **Sqrt:** a=0x800000, Sqrt_odd_SI=1, P=0 -> Result=0x16A09E6, Sticky=1, Done at cycle 26.
- **Kill:** Kill_SI at cycle 5 of a division -> Ready_SO=1 at cycle 6, no Done_SO, Result_DO unchanged. A following Start completes correctly.
- **Throughput/reset:** ITER_PER_CYC=2, a=b=0x800000 -> Done at cycle 14. A Start in the Done cycle is accepted. Rst_RI mid-ITER -> outputs 0, Ready_SO=1 without waiting for a clock edge.
